info_writer: RTL

- Write-side counterpart of the FPGA debug read path. Operators deposit 32-bit words into instruction memory, the register file, or data memory from switches and keys.
- Assembles the word from two 16-bit switch halves and issues a single valid/ready write toward the selected target.
- Sits in fpgaController between the board I/O conditioning and the CPU storage write ports.

---
 rtl/fpga_ctrl_pkg.sv | 25 ++
 rtl/key_edge.sv | 27 ++
 rtl/info_writer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fpga_ctrl_pkg.sv
// Shared types and default widths for the FPGA controller write path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpga_ctrl_pkg;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_HALF_W         = 16;
    localparam int DEF_MEM_ADDR_W     = 10;
    localparam int DEF_INSTR_ADDR_W   = 8;
    localparam int DEF_REG_ADDR_W     = 5;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        TGT_INSTR = 2'd0,
        TGT_REG   = 2'd1,
        TGT_MEM   = 2'd2,
        TGT_NONE  = 2'd3
    } tgt_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for an already-synchronised key level.
// Latency: combinational edge, one-cycle history register.
// Backpressure: none; an edge not consumed in its cycle is lost.
module key_edge (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic prev_q, prev_d;

    always_comb begin
        prev_d = key;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = key & ~prev_q;

endmodule

// File: rtl/info_writer.sv
// Assembles a 32-bit word from switch halves and issues one write (INFO_WRITER_AUTO_INCREMENT_EN adds an address pointer).
// Latency: commit edge to wr_valid 1 cycle; wr_ready to done 1 cycle.
// Backpressure: holds wr_valid/target/addr/data until wr_ready, aborting with error after TIMEOUT_CYCLES.
module info_writer
    import fpga_ctrl_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int HALF_W         = DEF_HALF_W,
    parameter int MEM_ADDR_W     = DEF_MEM_ADDR_W,
    parameter int INSTR_ADDR_W   = DEF_INSTR_ADDR_W,
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [HALF_W-1:0]     switches,
    input  logic                  key_load_lo,
    input  logic                  key_load_hi,
    input  logic                  key_commit,
    input  logic [1:0]            select,
    input  logic [MEM_ADDR_W-1:0] address,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [1:0]            wr_target,
    output logic [MEM_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MEM_ADDR_W-1:0] INSTR_MASK = MEM_ADDR_W'((1 << INSTR_ADDR_W) - 1);
    localparam logic [MEM_ADDR_W-1:0] REG_MASK   = MEM_ADDR_W'((1 << REG_ADDR_W) - 1);
    localparam logic [MEM_ADDR_W-1:0] MEM_MASK   = {MEM_ADDR_W{1'b1}};

    typedef struct packed {
        logic [1:0]            tgt;
        logic [MEM_ADDR_W-1:0] addr;
    } wr_hdr_t;

    logic lo_rise, hi_rise, commit_rise;

    key_edge u_edge_lo     (.clock(clock), .reset(reset), .key(key_load_lo), .rise(lo_rise));
    key_edge u_edge_hi     (.clock(clock), .reset(reset), .key(key_load_hi), .rise(hi_rise));
    key_edge u_edge_commit (.clock(clock), .reset(reset), .key(key_commit),  .rise(commit_rise));

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    wr_hdr_t               hdr_q, hdr_d;
    logic [DATA_W-1:0]     word_q, word_d;
    logic [MEM_ADDR_W-1:0] raw_addr, req_addr;
    logic                  req_bad;

`ifdef INFO_WRITER_AUTO_INCREMENT_EN
    logic [MEM_ADDR_W-1:0] ptr_q, ptr_d;
    logic                  ptr_vld_q, ptr_vld_d;
    logic [1:0]            sel_q, sel_d;

    // A select change invalidates the pointer so the next commit reloads from the address port.
    always_comb begin
        ptr_d     = ptr_q;
        ptr_vld_d = ptr_vld_q;
        sel_d     = select;
        if (select != sel_q) begin
            ptr_vld_d = 1'b0;
        end else if (state_q == ST_DONE) begin
            ptr_vld_d = 1'b1;
            case (hdr_q.tgt)
                TGT_INSTR: ptr_d = (hdr_q.addr + MEM_ADDR_W'(1)) & INSTR_MASK;
                TGT_REG:   ptr_d = (hdr_q.addr == REG_MASK) ? MEM_ADDR_W'(1)
                                                            : hdr_q.addr + MEM_ADDR_W'(1);
                default:   ptr_d = (hdr_q.addr + MEM_ADDR_W'(1)) & MEM_MASK;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q     <= '0;
            ptr_vld_q <= 1'b0;
            sel_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            ptr_vld_q <= ptr_vld_d;
            sel_q     <= sel_d;
        end
    end

    assign raw_addr = ptr_vld_q ? ptr_q : address;
`else
    assign raw_addr = address;
`endif

    always_comb begin
        case (select)
            TGT_INSTR: req_addr = raw_addr & INSTR_MASK;
            TGT_REG:   req_addr = raw_addr & REG_MASK;
            default:   req_addr = raw_addr & MEM_MASK;
        endcase
        // Register 0 is hardwired to zero, so a write to it is refused.
        req_bad = (select == TGT_NONE) || ((select == TGT_REG) && (req_addr == '0));
    end

    always_comb begin
        word_d = word_q;
        if (state_q != ST_WRITE) begin
            if (lo_rise) word_d[HALF_W-1:0]      = switches;
            if (hi_rise) word_d[DATA_W-1:HALF_W] = switches;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        hdr_d   = hdr_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_rise) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        hdr_d.tgt  = select;
                        hdr_d.addr = req_addr;
                        err_d      = 1'b0;
                        cnt_d      = '0;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            hdr_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hdr_q   <= hdr_d;
            word_q  <= word_d;
        end
    end

    assign wr_valid  = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign error     = err_q;
    assign wr_target = hdr_q.tgt;
    assign wr_addr   = hdr_q.addr;
    assign wr_data   = word_q;

endmodule
